// File: rtl/herzel_sched_if.sv
// herzel_sched_if: control/data bundle between the Goertzel scheduler and its
// environment. slave = scheduler side, master = environment (channels, CORDIC).
interface herzel_sched_if #(
    parameter int NF = 11
);
    logic                 start_i;
    logic                 abort_i;
    logic [NF-1:0]        chan_mask_i;
    logic                 valid_angel_i;
    logic                 valid_cordic_i;
    logic                 smp_valid_i;
    logic [NF-1:0]        valid_herzel_i;
    logic [NF-1:0][31:0]  data_arr_i;
    logic                 en_cordic_o;
    logic                 clr_o;
    logic                 smp_en_o;
    logic [NF-1:0][31:0]  res_arr_o;
    logic                 busy_o;
    logic                 done_o;
    logic [1:0]           err_o;

    modport slave (
        input  start_i, abort_i, chan_mask_i,
        input  valid_angel_i, valid_cordic_i, smp_valid_i,
        input  valid_herzel_i, data_arr_i,
        output en_cordic_o, clr_o, smp_en_o,
        output res_arr_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, abort_i, chan_mask_i,
        output valid_angel_i, valid_cordic_i, smp_valid_i,
        output valid_herzel_i, data_arr_i,
        input  en_cordic_o, clr_o, smp_en_o,
        input  res_arr_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/herzel_sched.sv
// herzel_sched: measurement sequencer for an NF-channel Goertzel bank.
// Ports: clk, rst (async, active-high), bus (herzel_sched_if.slave).
module herzel_sched #(
    parameter int NF  = 11,
    parameter int NS  = 1000,
    parameter int TMO = 65535
) (
    input  logic           clk,
    input  logic           rst,
    herzel_sched_if.slave  bus
);
    localparam int SW = $clog2(NS + 1);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CORDIC,
        S_ACCUM,
        S_WAIT,
        S_LATCH
    } state_t;

    state_t               state, state_n;
    logic [SW-1:0]        smp_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic [NF-1:0]        mask_q;
    logic [1:0]           err_q;
    logic                 done_q;
    logic [NF-1:0][31:0]  res_q;

    logic abort_hit;
    logic tmo_hit;
    logic coef_rdy;
    logic last_smp;
    logic all_vld;

    assign abort_hit = bus.abort_i && (state != S_IDLE);
    assign tmo_hit   = (tmo_cnt == TW'(TMO - 1));
    assign coef_rdy  = bus.valid_angel_i && bus.valid_cordic_i;
    assign last_smp  = bus.smp_valid_i && (smp_cnt == SW'(NS - 1));
    assign all_vld   = ((bus.valid_herzel_i & mask_q) == mask_q);

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:
                if (bus.start_i && (bus.chan_mask_i != '0))
                    state_n = S_CLEAR;
            S_CLEAR:
                state_n = S_CORDIC;
            S_CORDIC:
                if (coef_rdy)     state_n = S_ACCUM;
                else if (tmo_hit) state_n = S_IDLE;
            S_ACCUM:
                if (last_smp) state_n = S_WAIT;
            S_WAIT:
                if (all_vld)      state_n = S_LATCH;
                else if (tmo_hit) state_n = S_IDLE;
            S_LATCH:
                state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
        // abort overrides every other transition
        if (abort_hit)
            state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt <= '0;
            tmo_cnt <= '0;
            mask_q  <= '0;
            err_q   <= 2'b00;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            done_q <= 1'b0;

            if (state != S_ACCUM)
                smp_cnt <= '0;
            else if (bus.smp_valid_i)
                smp_cnt <= smp_cnt + 1'b1;

            // restarts on every state change, so entry into CORDIC/WAIT sees 0
            if (state_n != state)
                tmo_cnt <= '0;
            else if (state == S_CORDIC || state == S_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (state == S_IDLE && bus.start_i) begin
                if (bus.chan_mask_i != '0) begin
                    mask_q <= bus.chan_mask_i;
                    err_q  <= 2'b00;
                end else begin
                    err_q  <= 2'b11;
                end
            end

            if (!abort_hit && state_n == S_IDLE) begin
                if (state == S_CORDIC) err_q <= 2'b01;
                if (state == S_WAIT)   err_q <= 2'b10;
            end

            if (state == S_LATCH && !abort_hit) begin
                done_q <= 1'b1;
                for (int k = 0; k < NF; k++)
                    res_q[k] <= mask_q[k] ? bus.data_arr_i[k] : 32'd0;
            end
        end
    end

    assign bus.busy_o      = (state != S_IDLE);
    assign bus.clr_o       = (state == S_CLEAR);
    assign bus.smp_en_o    = (state == S_ACCUM);
    assign bus.en_cordic_o = (state == S_CLEAR) || (state == S_CORDIC) ||
                             (state == S_ACCUM) || (state == S_WAIT);
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.res_arr_o   = res_q;
endmodule

// File: tb/tb_herzel_sched.sv
// tb_herzel_sched: directed vector table, hand sequences for timeout/abort/reset,
// then random stimulus against a behavioural model (NF=11, NS=4, TMO=16).
module tb_herzel_sched;
    localparam int NF  = 11;
    localparam int NS  = 4;
    localparam int TMO = 16;

    typedef logic [NF-1:0][31:0] arr_t;

    // expected control bundle {busy, clr, en_cordic, smp_en, done, err[1:0]}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_CLR  = 7'b1110000;
    localparam logic [6:0] C_COR  = 7'b1010000;
    localparam logic [6:0] C_ACC  = 7'b1011000;
    localparam logic [6:0] C_WT   = 7'b1010000;
    localparam logic [6:0] C_LAT  = 7'b1000000;
    localparam logic [6:0] C_DONE = 7'b0000100;
    localparam logic [6:0] C_REJ  = 7'b0000011;
    localparam logic [6:0] C_TO1  = 7'b0000001;

    typedef struct {
        logic          st;
        logic          ab;
        logic [NF-1:0] mk;
        logic          av;
        logic          cv;
        logic          sv;
        logic [NF-1:0] hv;
        logic [6:0]    ex;
    } vec_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nbad;

    herzel_sched_if #(.NF(NF)) bus ();

    herzel_sched #(.NF(NF), .NS(NS), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkv(logic st, logic ab, logic [NF-1:0] mk,
                                 logic av, logic cv, logic sv,
                                 logic [NF-1:0] hv, logic [6:0] ex);
        vec_t v;
        v.st = st; v.ab = ab; v.mk = mk; v.av = av;
        v.cv = cv; v.sv = sv; v.hv = hv; v.ex = ex;
        return v;
    endfunction

    task automatic drive(logic st, logic ab, logic [NF-1:0] mk,
                         logic av, logic cv, logic sv, logic [NF-1:0] hv);
        bus.start_i        = st;
        bus.abort_i        = ab;
        bus.chan_mask_i    = mk;
        bus.valid_angel_i  = av;
        bus.valid_cordic_i = cv;
        bus.smp_valid_i    = sv;
        bus.valid_herzel_i = hv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(string nm, logic [6:0] exp);
        logic [6:0] act;
        act = {bus.busy_o, bus.clr_o, bus.en_cordic_o, bus.smp_en_o,
               bus.done_o, bus.err_o};
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %b, wanted %b (busy clr en smp done err)",
                     nm, act, exp);
        end
    endtask

    task automatic check_res(string nm, arr_t exp);
        nvec++;
        if (bus.res_arr_o !== exp) begin
            nbad++;
            $display("FAIL %s: res got %h, wanted %h", nm, bus.res_arr_o, exp);
        end
    endtask

    task automatic check_int(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, wanted %0d", nm, act, exp);
        end
    endtask

    // behavioural model: phase of the measurement plus cycles spent in it
    localparam int P_IDLE = 0, P_CLR = 1, P_COR = 2, P_ACC = 3, P_WT = 4, P_LAT = 5;
    int            m_ph;
    int            m_cyc;
    int            m_smp;
    logic [NF-1:0] m_mk;
    logic [1:0]    m_err;
    logic          m_done;
    arr_t          m_res;

    task automatic model_step();
        m_done = 1'b0;
        if (m_ph != P_IDLE && bus.abort_i) begin
            m_ph = P_IDLE;
        end else if (m_ph == P_IDLE) begin
            if (bus.start_i) begin
                if (bus.chan_mask_i == 0) begin
                    m_err = 2'b11;
                end else begin
                    m_mk = bus.chan_mask_i; m_err = 2'b00; m_ph = P_CLR;
                end
            end
        end else if (m_ph == P_CLR) begin
            m_ph = P_COR; m_cyc = 0;
        end else if (m_ph == P_COR) begin
            m_cyc++;
            if (bus.valid_angel_i && bus.valid_cordic_i) begin
                m_ph = P_ACC; m_smp = 0;
            end else if (m_cyc == TMO) begin
                m_ph = P_IDLE; m_err = 2'b01;
            end
        end else if (m_ph == P_ACC) begin
            if (bus.smp_valid_i) m_smp++;
            if (m_smp == NS) begin
                m_ph = P_WT; m_cyc = 0;
            end
        end else if (m_ph == P_WT) begin
            m_cyc++;
            if ((bus.valid_herzel_i & m_mk) == m_mk) begin
                m_ph = P_LAT;
            end else if (m_cyc == TMO) begin
                m_ph = P_IDLE; m_err = 2'b10;
            end
        end else begin
            for (int k = 0; k < NF; k++)
                m_res[k] = m_mk[k] ? bus.data_arr_i[k] : 32'd0;
            m_done = 1'b1;
            m_ph = P_IDLE;
        end
    endtask

    function automatic logic [6:0] model_ctl();
        return {m_ph != P_IDLE, m_ph == P_CLR,
                m_ph >= P_CLR && m_ph <= P_WT, m_ph == P_ACC, m_done, m_err};
    endfunction

    vec_t tbl[$];
    arr_t ramp;
    arr_t exp_r;
    int   ncor;
    int   ndone;

    initial begin
        nvec = 0;
        nbad = 0;
        for (int k = 0; k < NF; k++) ramp[k] = 32'(k + 1);
        bus.data_arr_i = ramp;
        drive(0, 0, '0, 0, 0, 0, '0);
        rst = 1'b1;
        #2;
        check_ctl("reset_ctl", C_IDLE);
        check_res("reset_res", '0);
        tick();
        rst = 1'b0;

        // full run, mask 0x7FF
        tbl.push_back(mkv(1, 0, 11'h7FF, 0, 0, 0, 11'h000, C_CLR));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h000, C_COR));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_COR));
        tbl.push_back(mkv(0, 0, 11'h000, 1, 1, 0, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_ACC));
        tbl.push_back(mkv(1, 0, 11'h7FF, 0, 0, 0, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_WT));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h3FF, C_WT));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h7FF, C_LAT));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h000, C_DONE));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h000, C_IDLE));
        // partial mask 0x005
        tbl.push_back(mkv(1, 0, 11'h005, 0, 0, 0, 11'h000, C_CLR));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h000, C_COR));
        tbl.push_back(mkv(0, 0, 11'h000, 1, 1, 0, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_ACC));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 1, 11'h000, C_WT));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h005, C_LAT));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h000, C_DONE));
        // zero-mask rejection, then a valid start, then abort from CLEAR
        tbl.push_back(mkv(1, 0, 11'h000, 0, 0, 0, 11'h000, C_REJ));
        tbl.push_back(mkv(0, 0, 11'h000, 0, 0, 0, 11'h000, C_REJ));
        tbl.push_back(mkv(1, 0, 11'h7FF, 0, 0, 0, 11'h000, C_CLR));
        tbl.push_back(mkv(0, 1, 11'h000, 0, 0, 0, 11'h000, C_IDLE));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].mk, tbl[i].av,
                  tbl[i].cv, tbl[i].sv, tbl[i].hv);
            tick();
            check_ctl($sformatf("tbl%0d", i), tbl[i].ex);
            if (i == 12) check_res("full_res", ramp);
        end
        exp_r = '0;
        exp_r[0] = 32'd1;
        exp_r[2] = 32'd3;
        check_res("mask5_res", exp_r);

        // CORDIC timeout
        drive(1, 0, 11'h7FF, 0, 0, 0, '0);
        tick();
        drive(0, 0, '0, 1, 0, 0, '0);
        ncor = 0;
        ndone = 0;
        for (int i = 0; i < TMO; i++) begin
            tick();
            if (bus.busy_o && bus.en_cordic_o && !bus.clr_o) ncor++;
            if (bus.done_o) ndone++;
        end
        tick();
        check_int("cordic_cycles", ncor, TMO);
        check_ctl("cordic_tmo", C_TO1);
        check_int("tmo_no_done", ndone, 0);
        check_res("tmo_res_kept", exp_r);

        // abort on the 2nd strobe, then a full-length run
        drive(1, 0, 11'h7FF, 0, 0, 0, '0); tick();
        drive(0, 0, '0, 0, 0, 0, '0);      tick();
        drive(0, 0, '0, 1, 1, 0, '0);      tick();
        drive(0, 0, '0, 0, 0, 1, '0);      tick();
        drive(0, 1, '0, 0, 0, 1, '0);      tick();
        check_ctl("abort_idle", C_IDLE);
        drive(0, 0, '0, 0, 0, 0, '0);      tick();
        check_ctl("abort_no_done", C_IDLE);
        check_res("abort_res_kept", exp_r);
        drive(1, 0, 11'h7FF, 0, 0, 0, '0); tick();
        drive(0, 0, '0, 0, 0, 0, '0);      tick();
        drive(0, 0, '0, 1, 1, 0, '0);      tick();
        drive(0, 0, '0, 0, 0, 1, '0);
        for (int i = 0; i < NS - 1; i++) tick();
        check_ctl("rerun_3_strobes", C_ACC);
        tick();
        check_ctl("rerun_4_strobes", C_WT);

        // asynchronous reset in WAIT
        drive(0, 0, '0, 0, 0, 0, '0);
        #2;
        rst = 1'b1;
        #1;
        check_ctl("rst_wait_ctl", C_IDLE);
        check_res("rst_wait_res", '0);
        tick();
        rst = 1'b0;

        // random stimulus against the model
        m_ph = P_IDLE; m_cyc = 0; m_smp = 0; m_mk = '0;
        m_err = 2'b00; m_done = 1'b0; m_res = '0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom % 4 == 0, $urandom % 40 == 0,
                  ($urandom % 8 == 0) ? 11'h000 : 11'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom % 3 == 0) ? 11'h7FF : 11'($urandom));
            for (int k = 0; k < NF; k++) bus.data_arr_i[k] = $urandom;
            model_step();
            tick();
            check_ctl("rand_ctl", model_ctl());
            if (m_done || i % 32 == 0) check_res("rand_res", m_res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/herzel_sched.md
HERZEL_SCHED -- requirements
Module: herzel_sched

Interface
REQ-001 Parameter NF, default 11, number of Goertzel frequency channels.
REQ-002 Parameter NS, default 1000, samples per measurement.
REQ-003 Parameter TMO, default 65535, timeout in clk cycles for the CORDIC and WAIT states.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start_i  in  1  measurement request; level sampled in IDLE.
REQ-007 abort_i  in  1  cancel the current measurement.
REQ-008 chan_mask_i  in  NF  enabled channels; captured on an accepted start.
REQ-009 valid_angel_i / valid_cordic_i  in  1 each  angle and CORDIC coefficient ready.
REQ-010 smp_valid_i  in  1  input sample strobe.
REQ-011 valid_herzel_i  in  NF  per-channel result valid.
REQ-012 data_arr_i  in  NFx32  per-channel result data.
REQ-013 en_cordic_o  out  1  CORDIC enable.
REQ-014 clr_o  out  1  one-cycle clear of the Goertzel accumulators.
REQ-015 smp_en_o  out  1  sample gate into the channels.
REQ-016 res_arr_o  out  NFx32  latched results.
REQ-017 busy_o  out  1  high in any state other than IDLE.
REQ-018 done_o  out  1  one-cycle completion pulse.
REQ-019 err_o  out  2  00 none, 01 CORDIC timeout, 10 result timeout, 11 start rejected.

Function
REQ-020 FSM states: IDLE, CLEAR, CORDIC, ACCUM, WAIT, LATCH. The state is registered; en_cordic_o, clr_o, smp_en_o and busy_o decode from the state only.
REQ-021 IDLE: start_i=1 and chan_mask_i!=0 -> CLEAR; capture the mask and clear err_o to 00.
REQ-022 IDLE: start_i=1 and chan_mask_i==0 -> stay in IDLE and set err_o=11.
REQ-023 CLEAR: clr_o=1 for exactly one cycle -> CORDIC.
REQ-024 en_cordic_o=1 in CLEAR, CORDIC, ACCUM and WAIT; 0 in IDLE and LATCH.
REQ-025 CORDIC: valid_angel_i & valid_cordic_i in the same cycle -> ACCUM.
REQ-026 ACCUM: smp_en_o=1; a sample counter of width clog2(NS+1), zeroed on entry, increments on each smp_valid_i.
REQ-027 ACCUM: smp_valid_i while count==NS-1 -> WAIT; exactly NS strobes occur with smp_en_o=1.
REQ-028 WAIT: (valid_herzel_i & mask)==mask -> LATCH; unmasked valid bits are ignored.
REQ-029 LATCH: res_arr_o[k] <= data_arr_i[k] for masked k and 0 for unmasked k; done_o=1 on the next cycle; -> IDLE.
REQ-030 Timeout counter: zeroed on entry to CORDIC and to WAIT. Reaching TMO cycles in CORDIC -> IDLE with err_o=01; in WAIT -> IDLE with err_o=10. No done_o on timeout; res_arr_o is unchanged.
REQ-031 abort_i=1 in any non-IDLE state -> IDLE next cycle; abort takes priority over all same-cycle transitions. No done_o, res_arr_o unchanged, err_o unchanged.
REQ-032 start_i while busy_o=1 is ignored and is not queued.
REQ-033 err_o holds its value until the next accepted start or reset.
REQ-034 smp_valid_i outside ACCUM is ignored; smp_en_o=0.

Reset
REQ-035 rst=1 asynchronously forces IDLE and zeroes all outputs, counters, mask and res_arr_o, including mid-measurement.
REQ-036 The first cycle after rst deassertion evaluates start_i normally.

Verification
REQ-037 NF=11, NS=4, mask=0x7FF, valid_angel and valid_cordic 3 cycles after start, 4 strobes, all valid_herzel with data k+1 -> clr_o pulses once, smp_en_o covers 4 strobes, res_arr_o[k]=k+1, done_o single pulse, err_o=00.
REQ-038 mask=0x005, only valid_herzel[0] and [2] asserted -> LATCH reached, res_arr_o[1]=0, done_o=1.
REQ-039 TMO=16, valid_cordic_i held 0 -> IDLE after 16 CORDIC cycles, err_o=01, no done_o, res_arr_o unchanged from the prior run.
REQ-040 abort_i on the 2nd ACCUM strobe, same cycle as that strobe -> IDLE next cycle, busy_o=0, no done_o; a new start then runs a full NS-sample count.
REQ-041 start_i with mask=0 -> err_o=11, busy_o stays 0; a following valid start clears err_o to 00.
REQ-042 rst asserted during WAIT -> all outputs 0 immediately, without waiting for a clock edge.
